// File: rtl/output_drainer_mmap_req_arbiter_pkg.sv
// Shared sizing helpers for the drainer mmap request path (arbiter, ID FIFO, burst converter).
package output_drainer_mmap_req_arbiter_pkg;

  localparam int DEF_NUM_REQ         = 4;
  localparam int DEF_ADDR_WIDTH      = 64;
  localparam int DEF_MAX_OUTSTANDING = 8;
  localparam int LEN_WIDTH           = 32;

  // Ceiling log2, floored at 1 so single-bit fields never collapse to zero width.
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int id_width(input int num_req);
    return log2(num_req);
  endfunction

  function automatic int cnt_width(input int max_outstanding);
    return log2(max_outstanding) + 1;
  endfunction

endpackage

// File: rtl/output_drainer_mmap_req_id_fifo.sv
// In-order requester-ID FIFO; head is the requester owed the next completion.
// Push while full and pop while empty are ignored; clk_en freezes all state.
module output_drainer_mmap_req_id_fifo
  import output_drainer_mmap_req_arbiter_pkg::*;
#(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 8,
  localparam int PTR_W = log2(DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CNT_W'(DEPTH));
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign head   = r_mem[r_rd_ptr];
  assign count  = r_count;

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clk_en) begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en && w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/output_drainer_mmap_req_arbiter.sv
// Round-robin share of one burst-converter request port among NUM_REQ drainers,
// with bounded outstanding requests and in-order completion routing back to the issuer.
module output_drainer_mmap_req_arbiter
  import output_drainer_mmap_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = DEF_NUM_REQ,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clk_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [ADDR_WIDTH-1:0]           out_REQ_ADDR,
  output logic [LEN_WIDTH-1:0]            out_REQ_LEN,
  output logic                            out_REQ_VALID,
  input  logic                            in_REQ_READY,
  input  logic                            in_DONE_VALID,
  output logic [NUM_REQ-1:0]              done_valid,
  output logic                            busy,
  output logic                            err_underflow
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);

  logic [ID_W-1:0]       r_rr_ptr;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [LEN_WIDTH-1:0]  r_out_len;
  logic                  r_out_valid;
  logic [NUM_REQ-1:0]    r_done_valid;
  logic                  r_busy;
  logic                  r_err_underflow;

  logic                  w_slot_free;
  logic                  w_found;
  logic [ID_W-1:0]       w_win;
  logic                  w_grant;
  logic                  w_pop;
  logic                  w_underflow;
  logic [ID_W-1:0]       w_fifo_head;
  logic [CNT_W-1:0]      w_fifo_count;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic [CNT_W-1:0]      w_cnt_next;
  logic                  w_valid_next;
  logic [NUM_REQ-1:0]    w_done_onehot;
  logic [ID_W-1:0]       w_rr_next;

  assign w_slot_free = ~r_out_valid | in_REQ_READY;

  // Priority rotate: first asserted valid at or after the RR pointer, modulo NUM_REQ.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = ID_W'(idx);
      end
    end
  end

  // Full is judged on the registered count: a pop in this cycle never makes room for a push.
  assign w_grant     = clk_en & ~reset & w_slot_free & ~w_fifo_full & w_found;
  assign w_pop       = clk_en & in_DONE_VALID & ~w_fifo_empty;
  assign w_underflow = clk_en & in_DONE_VALID & w_fifo_empty;

  always_comb begin
    req_ready = '0;
    if (w_grant) req_ready[w_win] = 1'b1;
  end

  always_comb begin
    w_done_onehot = '0;
    w_done_onehot[w_fifo_head] = 1'b1;
  end

  assign w_rr_next    = (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
  assign w_cnt_next   = w_fifo_count + CNT_W'(w_grant) - CNT_W'(w_pop);
  assign w_valid_next = w_grant ? 1'b1 : (in_REQ_READY ? 1'b0 : r_out_valid);

  output_drainer_mmap_req_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .push      (w_grant),
    .push_data (w_win),
    .pop       (w_pop),
    .head      (w_fifo_head),
    .count     (w_fifo_count),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr        <= '0;
      r_out_addr      <= '0;
      r_out_len       <= '0;
      r_out_valid     <= 1'b0;
      r_done_valid    <= '0;
      r_busy          <= 1'b0;
      r_err_underflow <= 1'b0;
    end else if (clk_en) begin
      if (w_grant) begin
        r_out_addr <= req_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
        r_out_len  <= req_len[int'(w_win)*LEN_WIDTH +: LEN_WIDTH];
        r_rr_ptr   <= w_rr_next;
      end
      r_out_valid  <= w_valid_next;
      r_done_valid <= w_pop ? w_done_onehot : '0;
      r_busy       <= (w_cnt_next != '0) | w_valid_next;
      if (w_underflow) r_err_underflow <= 1'b1;
    end
  end

  assign out_REQ_ADDR  = r_out_addr;
  assign out_REQ_LEN   = r_out_len;
  assign out_REQ_VALID = r_out_valid;
  assign done_valid    = r_done_valid;
  assign busy          = r_busy;
  assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_output_drainer_mmap_req_arbiter.sv
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_output_drainer_mmap_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int MO = 8;

  logic            clk;
  logic            reset;
  logic            clk_en;
  logic [N*AW-1:0] req_addr;
  logic [N*32-1:0] req_len;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   out_REQ_ADDR;
  logic [31:0]     out_REQ_LEN;
  logic            out_REQ_VALID;
  logic            in_REQ_READY;
  logic            in_DONE_VALID;
  logic [N-1:0]    done_valid;
  logic            busy;
  logic            err_underflow;

  output_drainer_mmap_req_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .req_addr(req_addr), .req_len(req_len), .req_valid(req_valid), .req_ready(req_ready),
    .out_REQ_ADDR(out_REQ_ADDR), .out_REQ_LEN(out_REQ_LEN), .out_REQ_VALID(out_REQ_VALID),
    .in_REQ_READY(in_REQ_READY), .in_DONE_VALID(in_DONE_VALID),
    .done_valid(done_valid), .busy(busy), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus drive state
  logic        d_reset, d_en, d_rdy, d_done;
  logic        pend  [N];
  logic [63:0] paddr [N];
  logic [31:0] plen  [N];

  // Reference model
  logic        m_valid, m_err, m_busy;
  logic [63:0] m_addr;
  logic [31:0] m_len;
  logic [N-1:0] m_done;
  int          m_rr;
  int          m_q[$];
  int          last_grant;

  task automatic arm(input int i, input logic [63:0] a, input logic [31:0] l);
    pend[i] = 1'b1; paddr[i] = a; plen[i] = l;
  endtask

  task automatic step();
    int win;
    int h;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    reset = d_reset; clk_en = d_en; in_REQ_READY = d_rdy; in_DONE_VALID = d_done;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = pend[i];
      req_addr[i*AW +: AW]  = paddr[i];
      req_len[i*32 +: 32]   = plen[i];
    end
    win = -1;
    if (!d_reset && d_en && (!m_valid || d_rdy) && m_q.size() < MO)
      for (int k = 0; k < N; k++)
        if (win < 0 && pend[(m_rr + k) % N]) win = (m_rr + k) % N;
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    #1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    if (d_reset) begin
      m_valid = 0; m_addr = 0; m_len = 0; m_done = 0; m_err = 0; m_rr = 0; m_busy = 0;
      m_q.delete();
    end else if (d_en) begin
      m_done = '0;
      if (d_done) begin
        if (m_q.size() > 0) begin
          h = m_q.pop_front();
          m_done[h] = 1'b1;
        end else m_err = 1'b1;
      end
      if (win >= 0) begin
        m_valid = 1; m_addr = paddr[win]; m_len = plen[win];
        m_q.push_back(win);
        m_rr = (win + 1) % N;
      end else if (d_rdy) m_valid = 0;
      m_busy = (m_q.size() != 0) || m_valid;
    end
    last_grant = win;
    if (win >= 0) pend[win] = 1'b0;
    #1;
    check("out_valid", 64'(out_REQ_VALID), 64'(m_valid));
    check("out_addr", out_REQ_ADDR, m_addr);
    check("out_len", 64'(out_REQ_LEN), 64'(m_len));
    check("done_valid", 64'(done_valid), 64'(m_done));
    check("busy", 64'(busy), 64'(m_busy));
    check("err_underflow", 64'(err_underflow), 64'(m_err));
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    d_reset = 1; d_done = 0; d_en = 1;
    step();
    d_reset = 0;
  endtask

  task automatic drain();
    int guard;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    guard = 0;
    d_done = 1; d_rdy = 1;
    while (m_q.size() > 0 && guard < 20) begin
      step();
      guard++;
    end
    d_done = 0;
    step();
  endtask

  initial begin
    int ng;
    d_reset = 1; d_en = 1; d_rdy = 0; d_done = 0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; paddr[i] = 0; plen[i] = 0; end
    m_valid = 0; m_err = 0; m_busy = 0; m_addr = 0; m_len = 0; m_done = 0; m_rr = 0;
    last_grant = -1;
    step(); step();
    check("rst_valid", 64'(out_REQ_VALID), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    d_reset = 0;

    // Single request from requester 2
    do_reset();
    arm(2, 64'h1000, 32'h3FF); d_rdy = 1;
    step();
    check("single_grant", 64'(last_grant), 64'd2);
    check("single_addr", out_REQ_ADDR, 64'h1000);
    check("single_len", 64'(out_REQ_LEN), 64'h3FF);
    repeat (4) step();
    d_done = 1; step(); d_done = 0;
    check("single_done", 64'(done_valid), 64'b0100);
    check("single_idle", 64'(busy), 64'd0);
    step();
    check("single_done_clr", 64'(done_valid), 64'd0);

    // Fairness with all requesters continuously valid
    do_reset();
    d_rdy = 1;
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) arm(i, 64'(32'h100 * (j + 1) + i), 32'(j));
      step();
      check($sformatf("fair_%0d", j), 64'(last_grant), 64'(j % N));
    end
    drain();

    // Backpressure: one grant, payload held, resume when ready returns
    do_reset();
    arm(1, 64'hABCD_0000, 32'h40); d_rdy = 0;
    step();
    check("bp_first", 64'(last_grant), 64'd1);
    arm(0, 64'h10, 32'h1); arm(3, 64'h30, 32'h3);
    ng = 0;
    repeat (10) begin
      step();
      if (last_grant >= 0) ng++;
      check("bp_stable", out_REQ_ADDR, 64'hABCD_0000);
    end
    check("bp_nogrant", 64'(ng), 64'd0);
    d_rdy = 1; step();
    check("bp_resume", 64'(last_grant), 64'd3);
    drain();

    // Outstanding limit and no pop-to-push bypass
    do_reset();
    d_rdy = 1;
    for (int j = 0; j < MO; j++) begin arm(0, 64'(j), 32'(j)); step(); end
    arm(1, 64'h5555, 32'h55);
    step();
    check("lim_block", 64'(last_grant), 64'hFFFF_FFFF_FFFF_FFFF);
    d_done = 1; step(); d_done = 0;
    check("lim_pop_no_push", 64'(last_grant), 64'hFFFF_FFFF_FFFF_FFFF);
    check("lim_pop_done", 64'(done_valid), 64'b0001);
    step();
    check("lim_after", 64'(last_grant), 64'd1);
    drain();

    // Completion ordering
    do_reset();
    d_rdy = 1;
    arm(3, 64'h3000, 32'h3); step();
    arm(1, 64'h1000, 32'h1); step();
    arm(3, 64'h3100, 32'h4); step();
    step();
    d_done = 1;
    step(); check("ord_0", 64'(done_valid), 64'b1000);
    step(); check("ord_1", 64'(done_valid), 64'b0010);
    step(); check("ord_2", 64'(done_valid), 64'b1000);
    d_done = 0; step();

    // Randomized traffic, including clk_en stalls
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0)
          arm(i, {$urandom(), $urandom()}, $urandom());
      d_rdy  = ($urandom_range(0, 3) != 0);
      d_en   = ($urandom_range(0, 15) != 0);
      d_done = (m_q.size() > 0) && ($urandom_range(0, 1) == 0);
      step();
    end
    d_en = 1;
    drain();

    // Underflow, then reset with outstanding IDs
    do_reset();
    d_done = 1; step(); d_done = 0;
    check("uf_err", 64'(err_underflow), 64'd1);
    check("uf_nodone", 64'(done_valid), 64'd0);
    d_rdy = 1;
    for (int j = 0; j < 5; j++) begin arm(j % N, 64'(j), 32'(j)); step(); end
    check("uf_busy", 64'(busy), 64'd1);
    do_reset();
    check("rst_busy2", 64'(busy), 64'd0);
    check("rst_err2", 64'(err_underflow), 64'd0);
    for (int i = 0; i < N; i++) arm(i, 64'(i), 32'(i));
    step();
    check("rst_rr", 64'(last_grant), 64'd0);
    d_done = 1; step(); d_done = 0;
    check("rst_no_stale", 64'(done_valid), 64'b0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
